// File: rtl/fetch_queue_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_stage_if
// Handshake bundle between the fetch/queue stage and the decode side.
//   stall        decode -> fetch   1 = decode not accepting the head pair
//   branch_taken decode -> fetch   single-cycle redirect request
//   pc_input     decode -> fetch   redirect target byte address
//   first_inst   fetch  -> decode  head instruction (even slot)
//   second_inst  fetch  -> decode  head+1 instruction (odd slot)
//   pc_output    fetch  -> decode  byte address of first_inst
//   pair_valid   fetch  -> decode  head pair is meaningful
//   queue_count  fetch  -> decode  occupied queue entries
// CNT_W must equal clog2(QUEUE_DEPTH)+1 of the attached stage.
// ---------------------------------------------------------------------------
interface fetch_queue_stage_if #(
   parameter int CNT_W = 4
);
   logic             stall;
   logic             branch_taken;
   logic [31:0]      pc_input;
   logic [31:0]      first_inst;
   logic [31:0]      second_inst;
   logic [31:0]      pc_output;
   logic             pair_valid;
   logic [CNT_W-1:0] queue_count;

   modport master (
      output stall, branch_taken, pc_input,
      input  first_inst, second_inst, pc_output, pair_valid, queue_count
   );

   modport slave (
      input  stall, branch_taken, pc_input,
      output first_inst, second_inst, pc_output, pair_valid, queue_count
   );
endinterface

// File: rtl/fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// fetch_queue_stage
// Dual-issue instruction fetch feeding a decoupling queue. Each cycle with
// room for a full group, FETCH_WIDTH aligned big-endian words are read from
// the local byte-wide instruction memory and pushed with their byte PCs. The
// oldest even/odd pair is presented to decode; a taken branch flushes the
// queue and refills from the target group, padding an odd-word target with
// LNOP_WORD so the head always sits on an even slot.
//
// Ports
//   clock   in  rising-edge clock
//   reset   in  synchronous, active-low reset
//   fq      slave side of fetch_queue_stage_if (stall / redirect in,
//           head pair, pc, pair_valid and occupancy out)
//
// State | meaning
// ------+----------------------------------------------------------------
// RUN   | normal streaming; enqueue a group whenever free >= FETCH_WIDTH
// REFILL| queue just flushed; push the target's tail of its group next edge
// ---------------------------------------------------------------------------
module fetch_queue_stage #(
   parameter int          IMEM_BYTES  = 2048,
   parameter int          FETCH_WIDTH = 2,
   parameter int          QUEUE_DEPTH = 8,
   parameter string       INIT_FILE   = "",
   parameter logic [31:0] LNOP_WORD   = 32'h0020_0000
) (
   input  logic               clock,
   input  logic               reset,
   fetch_queue_stage_if.slave fq
);

   localparam int AW = $clog2(IMEM_BYTES);
   localparam int QW = $clog2(QUEUE_DEPTH);
   localparam int CW = QW + 1;
   localparam int FW = FETCH_WIDTH;
   localparam int GW = $clog2(FETCH_WIDTH);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_REFILL = 1'b1
   } state_e;

   logic [7:0] mem [IMEM_BYTES];

   state_e          state_q, state_d;
   logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
   logic [AW-1:2]   tgt_q, tgt_d;
   logic [QW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [QW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic [31:0]     q_word_q [QUEUE_DEPTH];
   logic [AW-1:0]   q_pc_q   [QUEUE_DEPTH];

   logic            pair_valid;
   logic            pop;
   logic            push_en;
   logic [AW-1:0]   grp_base;
   logic [AW-1:0]   tgt_grp;
   logic [GW-1:0]   tgt_k;
   int              first_lane;
   logic [FW-1:0]   lane_we;
   logic [QW-1:0]   lane_slot [FW];
   logic [31:0]     lane_word [FW];
   logic [AW-1:0]   lane_pc   [FW];

   logic            unused_pc_bits;
   assign unused_pc_bits = ^{fq.pc_input[31:AW], fq.pc_input[1:0]};

   // Words are big-endian and always word aligned, so the four byte
   // addresses never straddle the end of memory.
   function automatic logic [31:0] rd_word(input logic [AW-1:2] wa);
      return {mem[{wa, 2'd0}], mem[{wa, 2'd1}], mem[{wa, 2'd2}], mem[{wa, 2'd3}]};
   endfunction

   assign tgt_k   = tgt_q[GW+1:2];
   assign tgt_grp = {tgt_q[AW-1:GW+2], {(GW+2){1'b0}}};

   assign pair_valid = (count_q >= CW'(2));

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      tgt_d      = tgt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      pop        = 1'b0;
      push_en    = 1'b0;
      first_lane = 0;
      grp_base   = (state_q == ST_REFILL) ? tgt_grp : fetch_pc_q;

      if (fq.branch_taken) begin
         // Redirect wins over everything else this cycle, including a
         // pending refill: the old target's words are never pushed.
         state_d  = ST_REFILL;
         tgt_d    = fq.pc_input[AW-1:2];
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (state_q == ST_REFILL) begin
            // Start at the even slot of the target pair; the queue is empty
            // so there is always room for the partial group.
            push_en    = 1'b1;
            first_lane = int'(tgt_k) & ~1;
            state_d    = ST_RUN;
         end else begin
            push_en = (count_q <= CW'(QUEUE_DEPTH - FW));
         end

         pop = pair_valid && !fq.stall;

         if (push_en) begin
            wr_ptr_d   = wr_ptr_q + QW'(FW - first_lane);
            fetch_pc_d = grp_base + AW'(4 * FW);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + QW'(2);
         end
         count_d = count_q
                 + (push_en ? CW'(FW - first_lane) : CW'(0))
                 - (pop ? CW'(2) : CW'(0));
      end

      for (int j = 0; j < FW; j++) begin
         lane_we[j]   = push_en && (j >= first_lane);
         lane_slot[j] = wr_ptr_q + QW'(j - first_lane);
         lane_pc[j]   = grp_base + AW'(4 * j);
         // Odd-word target: the even partner before it is replaced by the pad.
         if ((state_q == ST_REFILL) && tgt_k[0] && (j == first_lane)) begin
            lane_word[j] = LNOP_WORD;
         end else begin
            lane_word[j] = rd_word(lane_pc[j][AW-1:2]);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= '0;
         tgt_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         tgt_q      <= tgt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Queue storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int j = 0; j < FW; j++) begin
            if (lane_we[j]) begin
               q_word_q[lane_slot[j]] <= lane_word[j];
               q_pc_q[lane_slot[j]]   <= lane_pc[j];
            end
         end
      end
   end

   assign fq.pair_valid  = pair_valid;
   assign fq.first_inst  = pair_valid ? q_word_q[rd_ptr_q] : 32'd0;
   assign fq.second_inst = pair_valid ? q_word_q[rd_ptr_q + QW'(1)] : 32'd0;
   assign fq.pc_output   = pair_valid ? 32'(q_pc_q[rd_ptr_q]) : 32'd0;
   assign fq.queue_count = count_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: three instances (FW=2 D=8 2 KiB,
// FW=4 D=8 2 KiB, FW=2 D=8 64 B) share clock and reset. Memory holds word
// W(i) = {10+i, 20+i, 30+i, 40+i} bytes at byte address 4*i.
module tb_fetch_queue_stage;

   localparam logic [31:0] LNOP = 32'h0020_0000;

   logic        clk   = 1'b0;
   logic        rst_b = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [96:0] got, exp;

   always #5 clk = ~clk;

   fetch_queue_stage_if #(.CNT_W(4)) if_a ();
   fetch_queue_stage_if #(.CNT_W(4)) if_b ();
   fetch_queue_stage_if #(.CNT_W(4)) if_c ();

   fetch_queue_stage #(.IMEM_BYTES(2048), .FETCH_WIDTH(2), .QUEUE_DEPTH(8))
      u_a (.clock(clk), .reset(rst_b), .fq(if_a));
   fetch_queue_stage #(.IMEM_BYTES(2048), .FETCH_WIDTH(4), .QUEUE_DEPTH(8))
      u_b (.clock(clk), .reset(rst_b), .fq(if_b));
   fetch_queue_stage #(.IMEM_BYTES(64), .FETCH_WIDTH(2), .QUEUE_DEPTH(8))
      u_c (.clock(clk), .reset(rst_b), .fq(if_c));

   function automatic logic [31:0] W(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {8'h10 + b, 8'h20 + b, 8'h30 + b, 8'h40 + b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      if_a.stall = 1'b0; if_a.branch_taken = 1'b0; if_a.pc_input = 32'd0;
      if_b.stall = 1'b0; if_b.branch_taken = 1'b0; if_b.pc_input = 32'd0;
      if_c.stall = 1'b0; if_c.branch_taken = 1'b0; if_c.pc_input = 32'd0;
   endtask

   task automatic do_reset();
      idle_all();
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
   endtask

   task automatic test_reset();
      idle_all();
      rst_b = 1'b0;
      tick();
      got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output}; exp = '0;
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL reset_a_outputs got=%h want=%h", got, exp); end
      n_cmp++; if (if_a.queue_count !== 4'd0) begin n_bad++; $display("FAIL reset_a_count got=%0d want=0", if_a.queue_count); end
      n_cmp++; if ({if_b.pair_valid, if_b.queue_count} !== 5'd0) begin n_bad++; $display("FAIL reset_b got=%h want=0", {if_b.pair_valid, if_b.queue_count}); end
      n_cmp++; if ({if_c.pair_valid, if_c.queue_count} !== 5'd0) begin n_bad++; $display("FAIL reset_c got=%h want=0", {if_c.pair_valid, if_c.queue_count}); end
      rst_b = 1'b1;
   endtask

   task automatic test_stream();
      for (int n = 0; n < 6; n++) begin
         tick();
         got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output};
         exp = {1'b1, W(2*n), W(2*n+1), 32'(8*n)};
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL stream_pair%0d got=%h want=%h", n, got, exp); end
      end
      n_cmp++; if (if_a.queue_count !== 4'd2) begin n_bad++; $display("FAIL stream_count got=%0d want=2", if_a.queue_count); end
   endtask

   task automatic test_stall();
      do_reset();
      if_a.stall = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         tick();
         got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output};
         exp = {1'b1, W(0), W(1), 32'd0};
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL stall_head%0d got=%h want=%h", n, got, exp); end
         n_cmp++; if (if_a.queue_count !== 4'((n < 4 ? n : 4) * 2)) begin n_bad++; $display("FAIL stall_count%0d got=%0d want=%0d", n, if_a.queue_count, (n < 4 ? n : 4) * 2); end
      end
      if_a.stall = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output};
         exp = {1'b1, W(2+2*n), W(3+2*n), 32'(8+8*n)};
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL release_pair%0d got=%h want=%h", n, got, exp); end
         n_cmp++; if (if_a.queue_count !== 4'd6) begin n_bad++; $display("FAIL release_count%0d got=%0d want=6", n, if_a.queue_count); end
      end
   endtask

   task automatic test_redirect_odd();
      do_reset();
      tick();
      tick();
      if_a.branch_taken = 1'b1; if_a.pc_input = 32'h14;
      tick();
      got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output}; exp = '0;
      n_cmp++; if (got !== exp || if_a.queue_count !== 4'd0) begin n_bad++; $display("FAIL odd_flush got=%h cnt=%0d want=0", got, if_a.queue_count); end
      if_a.branch_taken = 1'b0;
      tick();
      got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output};
      exp = {1'b1, LNOP, W(5), 32'h10};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL odd_pad_pair got=%h want=%h", got, exp); end
      for (int n = 0; n < 2; n++) begin
         tick();
         got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output};
         exp = {1'b1, W(6+2*n), W(7+2*n), 32'(24+8*n)};
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL odd_follow%0d got=%h want=%h", n, got, exp); end
      end
   endtask

   task automatic test_redirect_chain();
      if_a.branch_taken = 1'b1; if_a.pc_input = 32'h14;
      tick();
      if_a.pc_input = 32'hFFFF_F843;
      tick();
      n_cmp++; if ({if_a.pair_valid, if_a.queue_count} !== 5'd0) begin n_bad++; $display("FAIL chain_flush got=%h want=0", {if_a.pair_valid, if_a.queue_count}); end
      if_a.branch_taken = 1'b0;
      for (int n = 0; n < 2; n++) begin
         tick();
         got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output};
         exp = {1'b1, W(16+2*n), W(17+2*n), 32'(64+8*n)};
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL chain_pair%0d got=%h want=%h", n, got, exp); end
      end
   endtask

   task automatic test_redirect_full();
      do_reset();
      if_a.stall = 1'b1;
      for (int n = 0; n < 4; n++) tick();
      n_cmp++; if (if_a.queue_count !== 4'd8) begin n_bad++; $display("FAIL full_count got=%0d want=8", if_a.queue_count); end
      if_a.branch_taken = 1'b1; if_a.pc_input = 32'h20;
      tick();
      got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output}; exp = '0;
      n_cmp++; if (got !== exp || if_a.queue_count !== 4'd0) begin n_bad++; $display("FAIL full_flush got=%h cnt=%0d want=0", got, if_a.queue_count); end
      if_a.branch_taken = 1'b0;
      for (int n = 0; n < 2; n++) begin
         tick();
         got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output};
         exp = {1'b1, W(8), W(9), 32'h20};
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL full_refill%0d got=%h want=%h", n, got, exp); end
         n_cmp++; if (if_a.queue_count !== 4'(2+2*n)) begin n_bad++; $display("FAIL full_refill_cnt%0d got=%0d want=%0d", n, if_a.queue_count, 2+2*n); end
      end
      if_a.stall = 1'b0;
      for (int n = 0; n < 2; n++) begin
         tick();
         got = {if_a.pair_valid, if_a.first_inst, if_a.second_inst, if_a.pc_output};
         exp = {1'b1, W(10+2*n), W(11+2*n), 32'(40+8*n)};
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL full_after%0d got=%h want=%h", n, got, exp); end
      end
   endtask

   task automatic test_fw4();
      logic [31:0] tgts  [3];
      logic [31:0] f0    [3];
      int          f0_pc [3];
      int          f0_cnt[3];
      tgts   = '{32'h1C, 32'h18, 32'h14};
      f0     = '{LNOP, W(6), LNOP};
      f0_pc  = '{24, 24, 16};
      f0_cnt = '{2, 2, 4};
      do_reset();
      tick();
      got = {if_b.pair_valid, if_b.first_inst, if_b.second_inst, if_b.pc_output};
      exp = {1'b1, W(0), W(1), 32'd0};
      n_cmp++; if (got !== exp || if_b.queue_count !== 4'd4) begin n_bad++; $display("FAIL fw4_first got=%h cnt=%0d want=%h cnt=4", got, if_b.queue_count, exp); end
      for (int t = 0; t < 3; t++) begin
         if_b.branch_taken = 1'b1; if_b.pc_input = tgts[t];
         tick();
         n_cmp++; if ({if_b.pair_valid, if_b.queue_count} !== 5'd0) begin n_bad++; $display("FAIL fw4_flush%0d got=%h want=0", t, {if_b.pair_valid, if_b.queue_count}); end
         if_b.branch_taken = 1'b0;
         tick();
         got = {if_b.pair_valid, if_b.first_inst, if_b.second_inst, if_b.pc_output};
         exp = {1'b1, f0[t], W(f0_pc[t]/4 + 1), 32'(f0_pc[t])};
         n_cmp++; if (got !== exp || if_b.queue_count !== 4'(f0_cnt[t])) begin n_bad++; $display("FAIL fw4_refill%0d got=%h cnt=%0d want=%h cnt=%0d", t, got, if_b.queue_count, exp, f0_cnt[t]); end
         tick();
         got = {if_b.pair_valid, if_b.first_inst, if_b.second_inst, if_b.pc_output};
         exp = {1'b1, W(f0_pc[t]/4 + 2), W(f0_pc[t]/4 + 3), 32'(f0_pc[t] + 8)};
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL fw4_next%0d got=%h want=%h", t, got, exp); end
      end
   endtask

   task automatic test_wrap();
      int idx;
      do_reset();
      for (int n = 0; n < 10; n++) begin
         tick();
         idx = (2*n) % 16;
         got = {if_c.pair_valid, if_c.first_inst, if_c.second_inst, if_c.pc_output};
         exp = {1'b1, W(idx), W(idx+1), 32'(4*idx)};
         n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL wrap_pair%0d got=%h want=%h", n, got, exp); end
      end
      if_c.branch_taken = 1'b1; if_c.pc_input = 32'h14;
      tick();
      if_c.branch_taken = 1'b0;
      rst_b = 1'b0;
      tick();
      got = {if_c.pair_valid, if_c.first_inst, if_c.second_inst, if_c.pc_output}; exp = '0;
      n_cmp++; if (got !== exp || if_c.queue_count !== 4'd0) begin n_bad++; $display("FAIL rst_in_refill got=%h cnt=%0d want=0", got, if_c.queue_count); end
      rst_b = 1'b1;
      tick();
      tick();
      if_c.branch_taken = 1'b1; if_c.pc_input = 32'h14;
      rst_b = 1'b0;
      tick();
      got = {if_c.pair_valid, if_c.first_inst, if_c.second_inst, if_c.pc_output}; exp = '0;
      n_cmp++; if (got !== exp || if_c.queue_count !== 4'd0) begin n_bad++; $display("FAIL rst_with_branch got=%h cnt=%0d want=0", got, if_c.queue_count); end
      if_c.branch_taken = 1'b0;
      rst_b = 1'b1;
      tick();
      got = {if_c.pair_valid, if_c.first_inst, if_c.second_inst, if_c.pc_output};
      exp = {1'b1, W(0), W(1), 32'd0};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL after_rst_pair got=%h want=%h", got, exp); end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] w;
      idle_all();
      for (int i = 0; i < 512; i++) begin
         w = W(i);
         for (int b = 0; b < 4; b++) begin
            u_a.mem[4*i+b] = w[31-8*b -: 8];
            u_b.mem[4*i+b] = w[31-8*b -: 8];
            if (i < 16) u_c.mem[4*i+b] = w[31-8*b -: 8];
         end
      end
      test_reset();
      test_stream();
      test_stall();
      test_redirect_odd();
      test_redirect_chain();
      test_redirect_full();
      test_fw4();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
